// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Included by the arbiter FSM and the round-robin picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the two-port arbiter, grouped as one bundle.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_ack;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_ack;
  logic [DW-1:0] p1_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  logic          busy;
  logic          grant_id;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rd,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output mem_we, mem_a, mem_wd, busy, grant_id
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rd,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  mem_we, mem_a, mem_wd, busy, grant_id
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to ptr.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_CPU;
    unique case (req)
      2'b01:   gnt_id = PORT_CPU;
      2'b10:   gnt_id = PORT_AUX;
      2'b11:   gnt_id = ptr;
      default: gnt_id = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between two req/ack masters.
// Three-phase FSM (idle, access, response); every memory-side output is registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  arb_state_e    state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic          grant_q, grant_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [DW-1:0] mem_wd_q, mem_wd_d;
  logic          p0_ack_q, p0_ack_d;
  logic          p1_ack_q, p1_ack_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;

  logic gnt_valid;
  logic gnt_id;

  rr_pick2 u_pick (
    .req       ({bus.p1_req, bus.p0_req}),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    mem_we_d   = mem_we_q;
    mem_a_d    = mem_a_q;
    mem_wd_d   = mem_wd_q;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          state_d = StAccess;
          grant_d = gnt_id;
          if (gnt_id == PORT_AUX) begin
            mem_we_d = bus.p1_we;
            mem_a_d  = bus.p1_addr;
            mem_wd_d = bus.p1_wdata;
          end else begin
            mem_we_d = bus.p0_we;
            mem_a_d  = bus.p0_addr;
            mem_wd_d = bus.p0_wdata;
          end
        end
      end
      StAccess: begin
        // mem_rd still shows the pre-write word here, so a write acks with the old value.
        state_d  = StResp;
        mem_we_d = 1'b0;
        rr_ptr_d = other_port(grant_q);
        if (grant_q == PORT_AUX) begin
          p1_ack_d   = 1'b1;
          p1_rdata_d = bus.mem_rd;
        end else begin
          p0_ack_d   = 1'b1;
          p0_rdata_d = bus.mem_rd;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= PORT_CPU;
      grant_q    <= PORT_CPU;
      mem_we_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_wd_q   <= '0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      mem_we_q   <= mem_we_d;
      mem_a_q    <= mem_a_d;
      mem_wd_q   <= mem_wd_d;
      p0_ack_q   <= p0_ack_d;
      p1_ack_q   <= p1_ack_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_wd   = mem_wd_q;
  assign bus.p0_ack   = p0_ack_q;
  assign bus.p1_ack   = p1_ack_q;
  assign bus.p0_rdata = p0_rdata_q;
  assign bus.p1_rdata = p1_rdata_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = (state_q == StAccess) || (state_q == StResp);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level memory/arbitration model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Environment memory: combinational read, write on posedge.
  logic [31:0] mem      [64];
  logic [31:0] init_mem [64];
  logic [31:0] ref_mem  [64];
  logic [31:0] last_rd  [2];
  logic        load_mem = 1'b0;

  assign bus.mem_rd = mem[bus.mem_a[7:2]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
    end else if (bus.mem_we) begin
      mem[bus.mem_a[7:2]] <= bus.mem_wd;
    end
  end

  int checks = 0;
  int errors = 0;

  // Requester signals must stay stable while a request is outstanding.
  logic        prev_p0_req = 1'b0, prev_p0_ack = 1'b0, prev_p1_req = 1'b0, prev_p1_ack = 1'b0;
  logic [64:0] prev_p0_cmd = '0, prev_p1_cmd = '0;
  always @(posedge clk) begin
    if (reset_n && bus.p0_req && prev_p0_req && !bus.p0_ack && !prev_p0_ack)
      assert ({bus.p0_we, bus.p0_addr, bus.p0_wdata} == prev_p0_cmd)
        else $error("p0 request changed before ack");
    if (reset_n && bus.p1_req && prev_p1_req && !bus.p1_ack && !prev_p1_ack)
      assert ({bus.p1_we, bus.p1_addr, bus.p1_wdata} == prev_p1_cmd)
        else $error("p1 request changed before ack");
    prev_p0_req <= bus.p0_req;
    prev_p0_ack <= bus.p0_ack;
    prev_p0_cmd <= {bus.p0_we, bus.p0_addr, bus.p0_wdata};
    prev_p1_req <= bus.p1_req;
    prev_p1_ack <= bus.p1_ack;
    prev_p1_cmd <= {bus.p1_we, bus.p1_addr, bus.p1_wdata};
  end

  // Reference model: one access is atomic; returns the word before any write.
  function automatic logic [31:0] model_access(input logic port, input logic we,
                                               input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] old;
    old = ref_mem[addr[7:2]];
    if (we) ref_mem[addr[7:2]] = wdata;
    last_rd[port] = old;
    return old;
  endfunction

  function automatic logic get_ack(input logic port);
    return port ? bus.p1_ack : bus.p0_ack;
  endfunction

  function automatic logic [31:0] get_rdata(input logic port);
    return port ? bus.p1_rdata : bus.p0_rdata;
  endfunction

  task automatic set_port(input logic port, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Issue one request and wait (bounded) for its ack; lat counts falling edges after issue.
  task automatic run_txn(input logic port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output int lat, output logic saw_we);
    @(negedge clk);
    set_port(port, 1'b1, we, addr, wdata);
    lat = -1;
    saw_we = 1'b0;
    rdata = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.mem_we) saw_we = 1'b1;
      if (get_ack(port)) begin
        lat = c;
        rdata = get_rdata(port);
        break;
      end
    end
    set_port(port, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    return a;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.p0_ack, bus.p1_ack, bus.mem_we, bus.busy, bus.grant_id} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.p0_ack, bus.p1_ack, bus.mem_we, bus.busy, bus.grant_id});
    end
    checks++;
    if ({bus.mem_a, bus.mem_wd, bus.p0_rdata, bus.p1_rdata} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0",
               {bus.mem_a, bus.mem_wd, bus.p0_rdata, bus.p1_rdata});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    logic [31:0] rd, exp;
    int lat;
    logic saw_we;
    exp = model_access(1'b0, 1'b0, 32'h8, '0);
    run_txn(1'b0, 1'b0, 32'h8, '0, rd, lat, saw_we);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL read_latency: got %0d expected 2", lat); end
    checks++;
    if (rd !== 32'h20020005 || exp !== 32'h20020005) begin
      errors++; $display("FAIL read_word2: got %h expected 20020005", rd);
    end
    checks++;
    if (saw_we !== 1'b0) begin errors++; $display("FAIL read_no_we: got %b expected 0", saw_we); end
    for (int k = 0; k < 6; k++) begin
      logic port;
      logic [31:0] a;
      port = 1'($urandom_range(0, 1));
      a = rand_addr();
      exp = model_access(port, 1'b0, a, '0);
      run_txn(port, 1'b0, a, '0, rd, lat, saw_we);
      checks++;
      if (rd !== exp || lat !== 2) begin
        errors++;
        $display("FAIL rand_read: port %0d got %h/%0d expected %h/2", port, rd, lat, exp);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd, exp;
    int lat;
    logic saw_we;
    exp = model_access(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    run_txn(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, rd, lat, saw_we);
    checks++;
    if (rd !== exp || lat !== 2 || saw_we !== 1'b1) begin
      errors++;
      $display("FAIL write_old_value: got %h/%0d/%b expected %h/2/1", rd, lat, saw_we, exp);
    end
    exp = model_access(1'b1, 1'b0, 32'h10, '0);
    run_txn(1'b1, 1'b0, 32'h10, '0, rd, lat, saw_we);
    checks++;
    if (rd !== 32'hDEADBEEF || exp !== 32'hDEADBEEF) begin
      errors++; $display("FAIL readback: got %h expected deadbeef", rd);
    end
    for (int k = 0; k < 10; k++) begin
      logic port, we;
      logic [31:0] a, wd;
      port = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a = {24'd0, 4'd0, 2'($urandom_range(0, 3)), 2'b00};
      wd = $urandom;
      exp = model_access(port, we, a, wd);
      run_txn(port, we, a, wd, rd, lat, saw_we);
      checks++;
      if (rd !== exp || lat !== 2) begin
        errors++;
        $display("FAIL rand_rw: port %0d we %0b got %h expected %h", port, we, rd, exp);
      end
    end
  endtask

  task automatic test_contention();
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] wd [2];
    logic        exp_port;
    int          k, last_cyc;
    apply_reset();
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      we[p] = 1'($urandom_range(0, 1)); addr[p] = rand_addr(); wd[p] = $urandom;
      set_port(1'(p), 1'b1, we[p], addr[p], wd[p]);
    end
    k = 0;
    last_cyc = 0;
    exp_port = 1'b0;
    for (int c = 1; c <= 200 && k < 8; c++) begin
      @(negedge clk);
      if (bus.p0_ack && bus.p1_ack) begin
        checks++; errors++; $display("FAIL dual_ack: got both acks expected one");
      end else if (bus.p0_ack || bus.p1_ack) begin
        logic p;
        logic [31:0] exp, other_hold;
        p = bus.p1_ack;
        other_hold = last_rd[~p];
        exp = model_access(exp_port, we[exp_port], addr[exp_port], wd[exp_port]);
        checks++;
        if (p !== exp_port || bus.grant_id !== exp_port) begin
          errors++;
          $display("FAIL rr_order: txn %0d got port %0d grant %0d expected %0d",
                   k, p, bus.grant_id, exp_port);
        end
        checks++;
        if (get_rdata(p) !== exp) begin
          errors++; $display("FAIL rr_rdata: txn %0d got %h expected %h", k, get_rdata(p), exp);
        end
        checks++;
        if (get_rdata(~p) !== other_hold) begin
          errors++;
          $display("FAIL rr_hold: txn %0d got %h expected %h", k, get_rdata(~p), other_hold);
        end
        if (k > 0) begin
          checks++;
          if (c - last_cyc !== 3) begin
            errors++; $display("FAIL rr_spacing: txn %0d got %0d expected 3", k, c - last_cyc);
          end
        end else begin
          checks++;
          if (c !== 2) begin errors++; $display("FAIL first_latency: got %0d expected 2", c); end
        end
        last_cyc = c;
        we[p] = 1'($urandom_range(0, 1)); addr[p] = rand_addr(); wd[p] = $urandom;
        set_port(p, 1'b1, we[p], addr[p], wd[p]);
        exp_port = ~exp_port;
        k++;
      end
    end
    checks++;
    if (k !== 8) begin errors++; $display("FAIL rr_timeout: got %0d txns expected 8", k); end
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  // After a lone access by 'solo', a simultaneous request must go to the other port.
  task automatic test_rotation(input logic solo);
    logic [31:0] rd, exp;
    int lat, first_cyc;
    logic saw_we, winner, got_first, got_second;
    exp = model_access(solo, 1'b0, 32'h0, '0);
    run_txn(solo, 1'b0, 32'h0, '0, rd, lat, saw_we);
    checks++;
    if (rd !== exp) begin errors++; $display("FAIL rot_solo: got %h expected %h", rd, exp); end
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, 32'h8, '0);
    set_port(1'b1, 1'b1, 1'b0, 32'hC, '0);
    got_first = 1'b0;
    got_second = 1'b0;
    winner = 1'b0;
    first_cyc = 0;
    for (int c = 1; c <= 20 && !got_second; c++) begin
      @(negedge clk);
      if (!got_first && (bus.p0_ack || bus.p1_ack)) begin
        got_first = 1'b1;
        winner = bus.p1_ack;
        first_cyc = c;
        set_port(winner, 1'b0, 1'b0, '0, '0);
      end else if (got_first && get_ack(~winner)) begin
        got_second = 1'b1;
        checks++;
        if (c - first_cyc !== 3) begin
          errors++; $display("FAIL rot_second: got %0d expected 3", c - first_cyc);
        end
        set_port(~winner, 1'b0, 1'b0, '0, '0);
      end
    end
    checks++;
    if (!got_second || winner !== ~solo) begin
      errors++;
      $display("FAIL rot_winner: got %0d (done %b) expected %0d", winner, got_second, ~solo);
    end
    void'(model_access(~solo, 1'b0, (~solo) ? 32'hC : 32'h8, '0));
    void'(model_access(solo, 1'b0, solo ? 32'hC : 32'h8, '0));
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd, exp;
    int lat;
    logic saw_we, ack_seen;
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b1, 32'h4, 32'h12345678);
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL midw_access: got we %b busy %b expected 1 1", bus.mem_we, bus.busy);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_we, bus.busy, bus.p0_ack, bus.mem_a} !== 35'd0) begin
      errors++;
      $display("FAIL midw_async: got we %b busy %b ack %b a %h expected zeros",
               bus.mem_we, bus.busy, bus.p0_ack, bus.mem_a);
    end
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    ack_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      ack_seen = ack_seen | bus.p0_ack;
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      ack_seen = ack_seen | bus.p0_ack;
    end
    checks++;
    if (ack_seen !== 1'b0) begin errors++; $display("FAIL midw_no_ack: got 1 expected 0"); end
    exp = model_access(1'b0, 1'b0, 32'h4, '0);
    run_txn(1'b0, 1'b0, 32'h4, '0, rd, lat, saw_we);
    checks++;
    if (rd !== exp || rd === 32'h12345678) begin
      errors++; $display("FAIL midw_readback: got %h expected %h", rd, exp);
    end
  endtask

  task automatic test_idle_gap();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.mem_we, bus.p0_ack, bus.p1_ack} !== 4'b0) begin
        errors++;
        $display("FAIL idle_gap: cycle %0d got %b expected 0000", c,
                 {bus.busy, bus.mem_we, bus.p0_ack, bus.p1_ack});
      end
    end
  endtask

  initial begin
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
    init_mem[2] = 32'h20020005;
    init_mem[1] = 32'hCAFE0001;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_mem[i];
    last_rd[0] = '0;
    last_rd[1] = '0;
    load_mem = 1'b1;
    @(posedge clk);
    #1 load_mem = 1'b0;

    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_rotation(1'b1);
    test_rotation(1'b0);
    test_reset_mid_write();
    test_idle_gap();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified word memory of the multicycle MIPS between two requesters.
- Port 0 is the multicycle core (instruction fetch and data accesses). Port 1 is a secondary master (boot loader / debug DMA).
- Arbitration is round-robin with a three-phase FSM that registers every memory-side signal.
- Each requester uses a req/ack handshake.
- The memory has a combinational read and a write committed on posedge clk when we=1.

Parameters:
- AW, 32, address width; word-aligned, bits [1:0] passed through untouched.
- DW, 32, data width.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- p0_req  input  1  port 0 request; held with p0_we/p0_addr/p0_wdata stable until p0_ack
- p0_we  input  1  port 0 write (1) / read (0)
- p0_addr  input  AW  port 0 byte address
- p0_wdata  input  DW  port 0 write data
- p0_ack  output  1  one-cycle completion pulse for port 0
- p0_rdata  output  DW  port 0 read data, valid while p0_ack=1
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same directions, widths and meaning for port 1
- mem_we  output  1  memory write enable
- mem_a  output  AW  memory address
- mem_wd  output  DW  memory write data
- mem_rd  input  DW  memory combinational read data
- busy  output  1  high in ACCESS and RESP
- grant_id  output  1  port currently or last served

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, mem_we=0, mem_a=0, mem_wd=0, p0_ack=p1_ack=0, p0_rdata=p1_rdata=0, busy=0, grant_id=0, rr_ptr=0 (port 0 has priority).
- FSM states: IDLE, ACCESS, RESP.
- IDLE transitions:
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both req: grant the port selected by rr_ptr.
  - On grant, at the edge: latch addr/we/wdata into mem_a/mem_we/mem_wd, set grant_id, go to ACCESS.
- ACCESS:
  - Memory sees the registered mem_a/mem_we/mem_wd for exactly one cycle; a write commits at the end edge.
  - At the end edge: capture mem_rd into the granted port's rdata, clear mem_we, pulse that port's ack, toggle rr_ptr to the other port, go to RESP.
- RESP:
  - ack=1 for this cycle only, then back to IDLE.
  - No new request is sampled in RESP.
  - The requester may drop or re-raise req at the RESP-ending edge.
- Latency: req first seen high at edge N (in IDLE); memory access during cycle N+1; ack high in cycle N+2.
- Throughput: one access per 3 cycles.
- Write readback: the rdata returned for a write is the memory contents before the write (combinational read of the old word).
- Non-served port's rdata holds its previous value; its ack stays 0.
- mem_a is a pass-through of the requester address. Bits [1:0] are not checked; word alignment is the memory's concern.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1. Neither port waits more than one foreign transaction.
- A req dropped before grant is ignored with no side effect. Changing signals while req=1 and before ack is illegal; the bench checks this with an assertion.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously). A write in ACCESS is aborted, because mem_we drops before the next edge. No ack is issued for the aborted transaction.

Decomposition:
- Shared package mem_arb_pkg:
  - State encoding: IDLE=2'b00, ACCESS=2'b01, RESP=2'b10.
  - PORT_CPU=1'b0, PORT_AUX=1'b1.
- Sub-module rr_pick2:
  - Inputs: req[1:0], ptr.
  - Outputs: gnt_valid, gnt_id.
  - Purely combinational; the FSM instantiates it.
- Everything else stays in one module.

Test Plan:
1. Single read: memory word 2 = 32'h20020005; p0 reads addr 32'h8 -> p0_ack high 2 cycles after the sampling edge, p0_rdata=32'h20020005, mem_we never 1.
2. Single write then read: p1 writes 32'hDEADBEEF to addr 32'h10, then reads it -> write ack carries the old value; the next read returns 32'hDEADBEEF.
3. Contention: p0 and p1 request in the same cycle after reset -> p0 served first, p1 acked 3 cycles later. With both held high for 8 transactions, the grant_id sequence is 0,1,0,1,...
4. Priority rotation: p1 alone completes one access, then both request -> p0 is granted (rr_ptr points to 0).
5. Reset mid-write: p0 writes 32'h12345678 to addr 32'h4; reset_n asserted during ACCESS -> mem_we=0 immediately, p0_ack never pulses, and a later read of addr 32'h4 returns the original word.
6. Idle gap: no requests for 10 cycles -> busy=0, mem_we=0, both acks 0 throughout.
